// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 PRGA decryptor.
//   - Memory geometry (byte width, S RAM and message address widths)
//   - state_e: encoded FSM state. The order is meaningful: every state from
//     ST_WAIT_ACCESS through ST_NEXT_K holds the memory requests.
//   - Plaintext character window used by the optional key validity check
//     (macro RC4_VALID_CHECK_EN, see rc4_prga_fsm.sv).
package rc4_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int S_ADDR_WIDTH   = 8;
  localparam int MSG_ADDR_WIDTH = 5;
  localparam int MSG_LEN        = 32;

  localparam logic [7:0] CHAR_LO    = 8'h61;  // 'a'
  localparam logic [7:0] CHAR_HI    = 8'h7A;  // 'z'
  localparam logic [7:0] CHAR_SPACE = 8'h20;  // ' '

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_WAIT_ACCESS = 4'd1,
    ST_INIT        = 4'd2,
    ST_INC_I       = 4'd3,
    ST_READ_SI     = 4'd4,
    ST_LATCH_SI    = 4'd5,
    ST_READ_SJ     = 4'd6,
    ST_LATCH_SJ    = 4'd7,
    ST_WRITE_SI    = 4'd8,
    ST_WRITE_SJ    = 4'd9,
    ST_READ_F      = 4'd10,
    ST_LATCH_F     = 4'd11,
    ST_WRITE_DEC   = 4'd12,
    ST_NEXT_K      = 4'd13,
    ST_DONE        = 4'd14,
    ST_FAIL        = 4'd15
  } state_e;

  // Memory requests are held from WAIT_ACCESS through NEXT_K.
  function automatic logic holds_request(input state_e st);
    return (st >= ST_WAIT_ACCESS) && (st <= ST_NEXT_K);
  endfunction

  function automatic logic is_finished(input state_e st);
    return (st == ST_DONE) || (st == ST_FAIL);
  endfunction

  // Lower-case letter or space: anything else means the key was wrong.
  function automatic logic is_plain_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/rc4_prga_fsm_if.sv
// rc4_prga_fsm_if: start/finish handshake, arbitration and memory ports of
// the RC4 decryptor.
//   master: the decryptor (drives requests, addresses, write data/enables)
//   slave : controller, arbiter and memories
//
// Handshake semantics:
//   start/finish - start is level-sampled only while the decryptor is idle;
//     finish rises when the message is done (or the key is rejected) and stays
//     high until reset. key_invalid qualifies finish as a rejection.
//   request/grant - a request rises when the decryptor wants a memory and
//     stays high until the job ends; the arbiter raises the grant and holds it
//     for as long as the request is high. Grants are only looked at before
//     the first access, so they must not drop mid-job.
//   Memories have one cycle read latency: an address presented in cycle N
//   shows up on *_q during cycle N+1. The encrypted ROM needs no grant.
interface rc4_prga_fsm_if;

  logic                                 start;
  logic                                 finish;
  logic                                 key_invalid;
  logic                                 access_s_request;
  logic                                 access_s_granted;
  logic                                 access_dec_request;
  logic                                 access_dec_granted;
  logic [rc4_pkg::S_ADDR_WIDTH-1:0]     s_addr;
  logic [rc4_pkg::DATA_WIDTH-1:0]       s_data;
  logic                                 s_wren;
  logic [rc4_pkg::DATA_WIDTH-1:0]       s_q;
  logic [rc4_pkg::MSG_ADDR_WIDTH-1:0]   enc_addr;
  logic [rc4_pkg::DATA_WIDTH-1:0]       enc_q;
  logic [rc4_pkg::MSG_ADDR_WIDTH-1:0]   dec_addr;
  logic [rc4_pkg::DATA_WIDTH-1:0]       dec_data;
  logic                                 dec_wren;

  modport master (
    input  start, access_s_granted, access_dec_granted, s_q, enc_q,
    output finish, key_invalid, access_s_request, access_dec_request,
           s_addr, s_data, s_wren, enc_addr, dec_addr, dec_data, dec_wren
  );

  modport slave (
    output start, access_s_granted, access_dec_granted, s_q, enc_q,
    input  finish, key_invalid, access_s_request, access_dec_request,
           s_addr, s_data, s_wren, enc_addr, dec_addr, dec_data, dec_wren
  );

endinterface

// File: rtl/rc4_prga_fsm_comb_logic.sv
// rc4_prga_fsm_comb_logic: next-state logic of the RC4 PRGA sequencer.
//   state_i        : current state
//   start_i        : start level (only meaningful in IDLE)
//   s_granted_i    : S RAM grant
//   dec_granted_i  : decrypted RAM grant
//   k_i            : current message index
//   dec_valid_i    : current plaintext byte accepted (always 1 without the
//                    validity check)
//   state_d_o      : next state
module rc4_prga_fsm_comb_logic
  import rc4_pkg::*;
(
  input  state_e                    state_i,
  input  logic                      start_i,
  input  logic                      s_granted_i,
  input  logic                      dec_granted_i,
  input  logic [MSG_ADDR_WIDTH-1:0] k_i,
  input  logic                      dec_valid_i,
  output state_e                    state_d_o
);

  always_comb begin
    state_d_o = state_i;
    unique case (state_i)
      ST_IDLE:        if (start_i) state_d_o = ST_WAIT_ACCESS;
      ST_WAIT_ACCESS: if (s_granted_i && dec_granted_i) state_d_o = ST_INIT;
      ST_INIT:        state_d_o = ST_INC_I;
      ST_INC_I:       state_d_o = ST_READ_SI;
      ST_READ_SI:     state_d_o = ST_LATCH_SI;
      ST_LATCH_SI:    state_d_o = ST_READ_SJ;
      ST_READ_SJ:     state_d_o = ST_LATCH_SJ;
      ST_LATCH_SJ:    state_d_o = ST_WRITE_SI;
      ST_WRITE_SI:    state_d_o = ST_WRITE_SJ;
      ST_WRITE_SJ:    state_d_o = ST_READ_F;
      ST_READ_F:      state_d_o = ST_LATCH_F;
      ST_LATCH_F:     state_d_o = ST_WRITE_DEC;
      ST_WRITE_DEC:   state_d_o = dec_valid_i ? ST_NEXT_K : ST_FAIL;
      ST_NEXT_K:      state_d_o = (k_i == MSG_ADDR_WIDTH'(MSG_LEN - 1)) ? ST_DONE : ST_INC_I;
      // Terminal until reset; a new start is ignored here.
      ST_DONE,
      ST_FAIL:        state_d_o = state_i;
      default:        state_d_o = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/vdff.sv
// vdff: enabled D flip-flop bank with synchronous active-high reset to 0.
//   clk, reset : clock / synchronous reset
//   en_i       : load enable
//   d_i, q_o   : data in / registered data out
module vdff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/rc4_prga_fsm.sv
// rc4_prga_fsm: RC4 pseudo-random generation loop over a 32-byte encrypted
// message. Starting from the permuted S array already in the S RAM, each byte
// takes 11 cycles: step i, read/latch S[i] (and advance j), read/latch S[j],
// swap them, read S[si+sj] with the encrypted byte, write f^ek to the
// decrypted RAM, advance k.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rc4_prga_fsm_if master (start/finish, request/grant, memories)
//   state_o    : current FSM state, for observation
// Optional feature, macro RC4_VALID_CHECK_EN: every plaintext byte must be a
// lower-case letter or space; the first byte that is not is not written and
// the FSM stops in FAIL with finish and key_invalid high. Without the macro
// all 32 bytes are written and key_invalid is constant 0.
module rc4_prga_fsm
  import rc4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rc4_prga_fsm_if.master       bus,
  output state_e               state_o
);

  state_e state_q, state_d;
  logic   req_q, finish_q;

  logic [DATA_WIDTH-1:0]     i_q, j_q, si_q, sj_q, f_q, ek_q;
  logic [DATA_WIDTH-1:0]     i_d, j_d;
  logic [MSG_ADDR_WIDTH-1:0] k_q, k_d;
  logic                      i_en, j_en, k_en;
  logic [DATA_WIDTH-1:0]     dec_byte;
  logic                      dec_valid;

  assign dec_byte = f_q ^ ek_q;

`ifdef RC4_VALID_CHECK_EN
  logic key_invalid_q;
  assign dec_valid       = is_plain_char(dec_byte);
  assign bus.key_invalid = key_invalid_q;
`else
  assign dec_valid       = 1'b1;
  assign bus.key_invalid = 1'b0;
`endif

  rc4_prga_fsm_comb_logic u_next (
    .state_i       (state_q),
    .start_i       (bus.start),
    .s_granted_i   (bus.access_s_granted),
    .dec_granted_i (bus.access_dec_granted),
    .k_i           (k_q),
    .dec_valid_i   (dec_valid),
    .state_d_o     (state_d)
  );

  // State plus the state-derived handshake flags, registered from the next
  // state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= 1'b0;
      finish_q      <= 1'b0;
`ifdef RC4_VALID_CHECK_EN
      key_invalid_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_q         <= holds_request(state_d);
      finish_q      <= is_finished(state_d);
`ifdef RC4_VALID_CHECK_EN
      key_invalid_q <= (state_d == ST_FAIL);
`endif
    end
  end

  assign state_o                = state_q;
  assign bus.finish             = finish_q;
  assign bus.access_s_request   = req_q;
  assign bus.access_dec_request = req_q;

  // Index registers: cleared in INIT, stepped in their own loop states.
  assign i_en = (state_q == ST_INIT) || (state_q == ST_INC_I);
  assign i_d  = (state_q == ST_INIT) ? '0 : i_q + 8'd1;
  assign j_en = (state_q == ST_INIT) || (state_q == ST_LATCH_SI);
  assign j_d  = (state_q == ST_INIT) ? '0 : j_q + bus.s_q;
  // k stays at 31 once the last byte is out.
  assign k_en = (state_q == ST_INIT) ||
                ((state_q == ST_NEXT_K) && (k_q != MSG_ADDR_WIDTH'(MSG_LEN - 1)));
  assign k_d  = (state_q == ST_INIT) ? '0 : k_q + 5'd1;

  vdff #(.WIDTH(DATA_WIDTH)) u_i (
    .clk(clk), .reset(reset), .en_i(i_en), .d_i(i_d), .q_o(i_q));
  vdff #(.WIDTH(DATA_WIDTH)) u_j (
    .clk(clk), .reset(reset), .en_i(j_en), .d_i(j_d), .q_o(j_q));
  vdff #(.WIDTH(DATA_WIDTH)) u_si (
    .clk(clk), .reset(reset), .en_i(state_q == ST_LATCH_SI), .d_i(bus.s_q), .q_o(si_q));
  vdff #(.WIDTH(DATA_WIDTH)) u_sj (
    .clk(clk), .reset(reset), .en_i(state_q == ST_LATCH_SJ), .d_i(bus.s_q), .q_o(sj_q));
  vdff #(.WIDTH(DATA_WIDTH)) u_f (
    .clk(clk), .reset(reset), .en_i(state_q == ST_LATCH_F), .d_i(bus.s_q), .q_o(f_q));
  vdff #(.WIDTH(DATA_WIDTH)) u_ek (
    .clk(clk), .reset(reset), .en_i(state_q == ST_LATCH_F), .d_i(bus.enc_q), .q_o(ek_q));
  vdff #(.WIDTH(MSG_ADDR_WIDTH)) u_k (
    .clk(clk), .reset(reset), .en_i(k_en), .d_i(k_d), .q_o(k_q));

  // Memory port decode. Read addresses are held through the LATCH state that
  // captures the data. The f index uses the pre-swap si/sj, whose sum equals
  // the post-swap S[i]+S[j]. When i==j both swap writes hit one word with the
  // same value, so no special case is needed.
  always_comb begin
    bus.s_addr   = '0;
    bus.s_data   = '0;
    bus.s_wren   = 1'b0;
    bus.enc_addr = '0;
    bus.dec_addr = '0;
    bus.dec_data = '0;
    bus.dec_wren = 1'b0;
    unique case (state_q)
      ST_READ_SI, ST_LATCH_SI: bus.s_addr = i_q;
      ST_READ_SJ, ST_LATCH_SJ: bus.s_addr = j_q;
      ST_WRITE_SI: begin
        bus.s_addr = i_q;
        bus.s_data = sj_q;
        bus.s_wren = 1'b1;
      end
      ST_WRITE_SJ: begin
        bus.s_addr = j_q;
        bus.s_data = si_q;
        bus.s_wren = 1'b1;
      end
      ST_READ_F, ST_LATCH_F: begin
        bus.s_addr   = si_q + sj_q;
        bus.enc_addr = k_q;
      end
      ST_WRITE_DEC: begin
        bus.dec_addr = k_q;
        bus.dec_data = dec_byte;
        bus.dec_wren = dec_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_fsm.sv
// tb_rc4_prga_fsm: bench for rc4_prga_fsm with behavioural S RAM, encrypted
// ROM and decrypted RAM (one cycle read latency), a software RC4 PRGA model
// and a scoreboard of expected decrypted-RAM writes.
module tb_rc4_prga_fsm;
  import rc4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic gnt_en;
  state_e state_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rc4_prga_fsm_if bus ();

  rc4_prga_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .state_o (state_dbg)
  );

  assign bus.access_s_granted   = gnt_en;
  assign bus.access_dec_granted = gnt_en;

  // ---------------- memory models ----------------
  logic [7:0] s_mem   [256];
  logic [7:0] enc_mem [32];
  logic [7:0] dec_mem [32];
  int         s_wr_cnt;
  int         dec_wr_cnt;

  always @(posedge clk) begin
    bus.s_q   <= s_mem[bus.s_addr];
    bus.enc_q <= enc_mem[bus.enc_addr];
    if (bus.s_wren) begin
      s_mem[bus.s_addr] = bus.s_data;
      s_wr_cnt = s_wr_cnt + 1;
    end
    if (bus.dec_wren) begin
      dec_mem[bus.dec_addr] = bus.dec_data;
      dec_wr_cnt = dec_wr_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: {dec_addr, dec_data} of every expected decrypted-RAM write.
  logic [12:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.dec_wren) begin
      if (exp_q.size() == 0) begin
        chk("dec_write_unexpected", {51'd0, bus.dec_addr, bus.dec_data}, 64'h1fff_ffff);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("dec_write", {51'd0, bus.dec_addr, bus.dec_data}, {51'd0, e});
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] m_s   [256];
  logic [7:0] m_ks  [32];
  logic [7:0] pt_buf[32];

  // Textbook RC4 PRGA on m_s: fills m_ks, leaves the final S in m_s.
  task automatic model_prga();
    logic [7:0] mi, mj, t;
    mi = 8'd0;
    mj = 8'd0;
    for (int k = 0; k < 32; k++) begin
      mi = mi + 8'd1;
      mj = mj + m_s[mi];
      t = m_s[mi];
      m_s[mi] = m_s[mj];
      m_s[mj] = t;
      m_ks[k] = m_s[8'(m_s[mi] + m_s[mj])];
    end
  endtask

  localparam int NVEC = 5;
  typedef struct {
    int         k;
    logic [7:0] enc;
    logic [7:0] dec;
  } vec_t;
  vec_t vecs[NVEC];

  // Snapshot S, run the model, fill the ROM (keeping the hand-written head if
  // asked) from pt_buf, and queue the expected decrypted writes.
  task automatic prepare_run(input bit keep_head);
    for (int x = 0; x < 256; x++) m_s[x] = s_mem[x];
    model_prga();
    for (int k = 0; k < 32; k++) begin
      if (!(keep_head && k < NVEC)) enc_mem[k] = pt_buf[k] ^ m_ks[k];
      exp_q.push_back({5'(k), enc_mem[k] ^ m_ks[k]});
    end
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b0;
    gnt_en    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_outputs"},
        {24'd0, bus.finish, bus.key_invalid, bus.access_s_request, bus.access_dec_request,
         bus.s_addr, bus.s_data, bus.s_wren, bus.enc_addr, bus.dec_addr, bus.dec_data,
         bus.dec_wren}, 64'd0);
    chk({name, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  // Start a job in the current negedge cycle (cycle 0) and follow it
  // negedge by negedge; cnt is the cycle number relative to the start cycle.
  // grant_delay > 0: grants stay low through cycle grant_delay.
  // reset_at > 0   : reset is driven in that cycle and the job abandoned.
  // exp_fin > 0    : cycle in which finish must first be seen high.
  task automatic run_decrypt(input int grant_delay, input int reset_at,
                             input bit chk_s23, input int exp_fin);
    int cnt;
    int dec_base;
    int wr_base;
    bit s23_done;
    dec_base = dec_wr_cnt;
    wr_base  = s_wr_cnt + dec_wr_cnt;
    s23_done = 1'b0;
    gnt_en   = (grant_delay == 0);
    @(negedge clk);
    bus.start = 1'b1;
    cnt = 0;
    while (1) begin
      @(negedge clk);
      cnt++;
      bus.start = 1'b0;
      if (grant_delay > 0 && cnt <= grant_delay) begin
        chk("wait_state", 64'(state_dbg), 64'(ST_WAIT_ACCESS));
        chk("wait_requests", {62'd0, bus.access_s_request, bus.access_dec_request}, 64'd3);
        if (cnt == grant_delay) begin
          chk("wait_no_writes", 64'(s_wr_cnt + dec_wr_cnt - wr_base), 64'd0);
          gnt_en = 1'b1;
        end
      end
      if (chk_s23 && !s23_done && (dec_wr_cnt - dec_base == 2)) begin
        s23_done = 1'b1;
        chk("s2_after_byte1", 64'(s_mem[2]), 64'd3);
        chk("s3_after_byte1", 64'(s_mem[3]), 64'd2);
      end
      if (reset_at > 0 && cnt == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_outputs_zero("mid_reset");
        exp_q.delete();
        return;
      end
      if (bus.finish) begin
        if (exp_fin > 0) chk("finish_cycle", 64'(cnt), 64'(exp_fin));
        break;
      end
      if (cnt >= 2000) begin
        chk("finish_timeout", 64'(cnt), 64'(exp_fin));
        break;
      end
    end
  endtask

  task automatic post_run_checks(input string name);
    int mism;
    mism = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) mism++;
    chk({name, "_final_s_mismatches"}, 64'(mism), 64'd0);
    chk({name, "_missing_dec_writes"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_requests_done"}, {62'd0, bus.access_s_request, bus.access_dec_request}, 64'd0);
    chk({name, "_key_invalid"}, 64'(bus.key_invalid), 64'd0);
    chk({name, "_state_done"}, 64'(state_dbg), 64'(ST_DONE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int r;
    int dec_before;
    logic [7:0] t;
    n_pass = 0;
    n_total = 0;
    s_wr_cnt = 0;
    dec_wr_cnt = 0;
    reset = 1'b1;
    gnt_en = 1'b0;
    bus.start = 1'b0;
    for (int x = 0; x < 32; x++) begin
      enc_mem[x] = 8'd0;
      dec_mem[x] = 8'd0;
    end
    load_identity();

    // Identity S: keystream 02,05,07,0D,0D for bytes 0..4 -> "abcde".
    vecs[0] = '{k: 0, enc: 8'h63, dec: 8'h61};
    vecs[1] = '{k: 1, enc: 8'h67, dec: 8'h62};
    vecs[2] = '{k: 2, enc: 8'h64, dec: 8'h63};
    vecs[3] = '{k: 3, enc: 8'h69, dec: 8'h64};
    vecs[4] = '{k: 4, enc: 8'h68, dec: 8'h65};

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    check_outputs_zero("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");

    // Identity S with hand-computed head, grants already high: finish in
    // cycle 355 (WAIT 1, INIT 2, 32*11 loop cycles 3..354, DONE 355).
    for (int v = 0; v < NVEC; v++) enc_mem[vecs[v].k] = vecs[v].enc;
    for (int k = 0; k < 32; k++) pt_buf[k] = 8'h61 + 8'(k % 26);
    prepare_run(1'b1);
    run_decrypt(0, 0, 1'b1, 355);
    for (int v = 0; v < NVEC; v++) chk("identity_dec_table", 64'(dec_mem[vecs[v].k]), 64'(vecs[v].dec));
    post_run_checks("identity");

    // start again after DONE must do nothing.
    dec_before = dec_wr_cnt;
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    chk("restart_state", 64'(state_dbg), 64'(ST_DONE));
    chk("restart_no_writes", 64'(dec_wr_cnt - dec_before), 64'd0);
    chk("restart_finish", 64'(bus.finish), 64'd1);

    // Grants withheld for 20 cycles: grant sampled at the end of cycle 20
    // instead of cycle 1, so finish moves 19 cycles later to 374.
    pulse_reset();
    load_identity();
    for (int k = 0; k < 32; k++) pt_buf[k] = 8'h7A - 8'(k % 26);
    prepare_run(1'b0);
    run_decrypt(20, 0, 1'b0, 374);
    post_run_checks("grant_wait");

    // Reset in cycle 100, then a full job from the partially swapped S.
    pulse_reset();
    load_identity();
    prepare_run(1'b0);
    run_decrypt(0, 100, 1'b0, 0);
    chk("mid_reset_queue_flushed", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < 32; k++) pt_buf[k] = (k % 5 == 4) ? 8'h20 : 8'h6B + 8'(k % 4);
    prepare_run(1'b0);
    run_decrypt(0, 0, 1'b0, 355);
    post_run_checks("after_mid_reset");

    // Random permutations against the reference model.
    for (int n = 0; n < 10; n++) begin
      pulse_reset();
      load_identity();
      for (int x = 255; x > 0; x--) begin
        r = $urandom_range(x, 0);
        t = s_mem[x];
        s_mem[x] = s_mem[r];
        s_mem[r] = t;
      end
      for (int k = 0; k < 32; k++) begin
        r = $urandom_range(26, 0);
        pt_buf[k] = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
      end
      prepare_run(1'b0);
      run_decrypt(0, 0, 1'b0, 355);
      post_run_checks("random");
    end

`ifdef RC4_VALID_CHECK_EN
    // Byte 0 decrypts to 8'h02: no write, FAIL in cycle 13 (INIT is 2,
    // WRITE_DEC of byte 0 is 12).
    pulse_reset();
    load_identity();
    enc_mem[0] = 8'h00;
    dec_before = dec_wr_cnt;
    run_decrypt(0, 0, 1'b0, 13);
    chk("bad_key_invalid", 64'(bus.key_invalid), 64'd1);
    chk("bad_key_finish", 64'(bus.finish), 64'd1);
    chk("bad_key_state", 64'(state_dbg), 64'(ST_FAIL));
    chk("bad_key_no_dec_write", 64'(dec_wr_cnt - dec_before), 64'd0);
    chk("bad_key_requests", {62'd0, bus.access_s_request, bus.access_dec_request}, 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
